// File: rtl/matrix_instr_sequencer.sv
// In-order CV-XIF offload sequencer: buffers issued matrix instructions, resolves commit/kill, dispatches one at a time.
// Optional MATRIX_SEQ_PERF_EN adds dispatched / killed-pop performance counters.
module matrix_instr_sequencer #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [31:0]           i_in_instr,
  input  logic [ID_WIDTH-1:0]   i_in_id,
  input  logic [DATA_WIDTH-1:0] i_in_rs1,
  input  logic [DATA_WIDTH-1:0] i_in_rs2,
  input  logic                  i_in_we,
  input  logic                  i_commit_valid,
  input  logic [ID_WIDTH-1:0]   i_commit_id,
  input  logic                  i_commit_kill,
  output logic                  o_acc_valid,
  input  logic                  i_acc_ready,
  output logic [31:0]           o_acc_instr,
  output logic [DATA_WIDTH-1:0] o_acc_rs1,
  output logic [DATA_WIDTH-1:0] o_acc_rs2,
  output logic [ID_WIDTH-1:0]   o_acc_id,
  input  logic                  i_acc_done,
  input  logic [DATA_WIDTH-1:0] i_acc_rd_data,
  output logic                  o_result_valid,
  input  logic                  i_result_ready,
  output logic [ID_WIDTH-1:0]   o_result_id,
  output logic [DATA_WIDTH-1:0] o_result_data,
`ifdef MATRIX_SEQ_PERF_EN
  output logic [31:0]           o_perf_dispatched,
  output logic [31:0]           o_perf_killed,
`endif
  output logic                  o_err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_PEND = 2'd0, ST_COMMITTED = 2'd1, ST_KILLED = 2'd2} stat_t;
  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_EXECUTE, S_RESULT} state_t;

  logic [31:0]           r_instr [DEPTH];
  logic [ID_WIDTH-1:0]   r_id    [DEPTH];
  logic [DATA_WIDTH-1:0] r_rs1   [DEPTH];
  logic [DATA_WIDTH-1:0] r_rs2   [DEPTH];
  logic                  r_we    [DEPTH];
  stat_t                 r_stat  [DEPTH];
  logic [PW:0]           r_head, r_tail;
  state_t                r_state, w_next;

  logic                  r_acc_valid, r_result_valid, r_err;
  logic [31:0]           r_acc_instr;
  logic [DATA_WIDTH-1:0] r_acc_rs1, r_acc_rs2, r_result_data;
  logic [ID_WIDTH-1:0]   r_acc_id, r_result_id;

  logic [PW-1:0]    w_head_idx, w_tail_idx;
  logic [PW:0]      w_count;
  logic             w_empty, w_full, w_push, w_pop, w_kill_pop, w_load_acc, w_load_res;
  logic [PW-1:0]    w_off [DEPTH];
  logic [DEPTH-1:0] w_valid, w_match;
  logic             w_enq_match, w_commit_err;
  stat_t            w_new_stat;

  assign w_head_idx = r_head[PW-1:0];
  assign w_tail_idx = r_tail[PW-1:0];
  assign w_count    = r_tail - r_head;
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_count == DEPTH_P);
  assign o_in_ready = !w_full;
  assign w_push     = i_in_valid && !w_full;
  assign w_new_stat = i_commit_kill ? ST_KILLED : ST_COMMITTED;

  // An entry is live when its distance from head is below the occupancy
  for (genvar g = 0; g < DEPTH; g++) begin : g_cam
    assign w_off[g]   = PW'(g) - w_head_idx;
    assign w_valid[g] = ({1'b0, w_off[g]} < w_count);
    assign w_match[g] = i_commit_valid && w_valid[g] && (r_id[g] == i_commit_id) &&
                        (r_stat[g] == ST_PEND);
  end

  assign w_enq_match  = i_commit_valid && w_push && (i_in_id == i_commit_id) && !(|w_match);
  assign w_commit_err = i_commit_valid && !(|w_match) && !w_enq_match;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_kill_pop = 1'b0;
    w_load_acc = 1'b0;
    w_load_res = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && r_stat[w_head_idx] == ST_KILLED) begin
          w_pop      = 1'b1;
          w_kill_pop = 1'b1;
        end else if (!w_empty && r_stat[w_head_idx] == ST_COMMITTED) begin
          w_next     = S_DISPATCH;
          w_load_acc = 1'b1;
        end
      end
      S_DISPATCH: if (i_acc_ready) w_next = S_EXECUTE;
      S_EXECUTE: begin
        if (i_acc_done) begin
          if (r_we[w_head_idx]) begin
            w_next     = S_RESULT;
            w_load_res = 1'b1;
          end else begin
            w_next = S_IDLE;
            w_pop  = 1'b1;
          end
        end
      end
      S_RESULT: begin
        if (i_result_ready) begin
          w_next = S_IDLE;
          w_pop  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Payload storage needs no reset; liveness comes from the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[w_tail_idx] <= i_in_instr;
      r_id[w_tail_idx]    <= i_in_id;
      r_rs1[w_tail_idx]   <= i_in_rs1;
      r_rs2[w_tail_idx]   <= i_in_rs2;
      r_we[w_tail_idx]    <= i_in_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      for (int i = 0; i < DEPTH; i++) r_stat[i] <= ST_PEND;
      r_acc_valid    <= 1'b0;
      r_acc_instr    <= '0;
      r_acc_rs1      <= '0;
      r_acc_rs2      <= '0;
      r_acc_id       <= '0;
      r_result_valid <= 1'b0;
      r_result_id    <= '0;
      r_result_data  <= '0;
      r_err          <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && w_tail_idx == PW'(i))
          r_stat[i] <= w_enq_match ? w_new_stat : ST_PEND;
        else if (w_match[i])
          r_stat[i] <= w_new_stat;
      end
      if (w_load_acc) begin
        r_acc_valid <= 1'b1;
        r_acc_instr <= r_instr[w_head_idx];
        r_acc_rs1   <= r_rs1[w_head_idx];
        r_acc_rs2   <= r_rs2[w_head_idx];
        r_acc_id    <= r_id[w_head_idx];
      end else if (r_acc_valid && i_acc_ready) begin
        r_acc_valid <= 1'b0;
      end
      if (w_load_res) begin
        r_result_valid <= 1'b1;
        r_result_id    <= r_id[w_head_idx];
        r_result_data  <= i_acc_rd_data;
      end else if (r_result_valid && i_result_ready) begin
        r_result_valid <= 1'b0;
      end
      if (w_commit_err || (i_acc_done && r_state != S_EXECUTE)) r_err <= 1'b1;
    end
  end

`ifdef MATRIX_SEQ_PERF_EN
  logic [31:0] r_perf_dispatched, r_perf_killed;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_dispatched <= '0;
      r_perf_killed     <= '0;
    end else begin
      if (r_acc_valid && i_acc_ready) r_perf_dispatched <= r_perf_dispatched + 32'd1;
      if (w_kill_pop)                 r_perf_killed     <= r_perf_killed + 32'd1;
    end
  end
  assign o_perf_dispatched = r_perf_dispatched;
  assign o_perf_killed     = r_perf_killed;
`endif

  assign o_acc_valid    = r_acc_valid;
  assign o_acc_instr    = r_acc_instr;
  assign o_acc_rs1      = r_acc_rs1;
  assign o_acc_rs2      = r_acc_rs2;
  assign o_acc_id       = r_acc_id;
  assign o_result_valid = r_result_valid;
  assign o_result_id    = r_result_id;
  assign o_result_data  = r_result_data;
  assign o_err          = r_err;
endmodule

// File: tb/tb_matrix_instr_sequencer.sv
// Scoreboard bench for matrix_instr_sequencer: bench-side accelerator model and result consumer.
module tb_matrix_instr_sequencer;
  localparam int IDW = 4;
  localparam int DW  = 64;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    instr;
    logic [DW-1:0]  rs1;
    logic [DW-1:0]  rs2;
    logic           we;
  } op_t;
  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_we, commit_valid, commit_kill;
  logic [31:0] in_instr, acc_instr;
  logic [IDW-1:0] in_id, commit_id, acc_id, result_id;
  logic [DW-1:0] in_rs1, in_rs2, acc_rs1, acc_rs2, acc_rd_data, result_data;
  logic acc_valid, acc_ready, acc_done, result_valid, result_ready, err;
`ifdef MATRIX_SEQ_PERF_EN
  logic [31:0] perf_dispatched, perf_killed;
`endif

  op_t  exp_disp[$];
  res_t exp_res[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic acc_hang = 1'b0;
  logic acc_busy = 1'b0;
  logic acc_in_exec = 1'b0;
  int   spur_req = 0;
  int   spur_ack = 0;

  always #5 clk = ~clk;

  matrix_instr_sequencer #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_instr(in_instr), .i_in_id(in_id),
    .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_we(in_we),
    .i_commit_valid(commit_valid), .i_commit_id(commit_id), .i_commit_kill(commit_kill),
    .o_acc_valid(acc_valid), .i_acc_ready(acc_ready), .o_acc_instr(acc_instr),
    .o_acc_rs1(acc_rs1), .o_acc_rs2(acc_rs2), .o_acc_id(acc_id),
    .i_acc_done(acc_done), .i_acc_rd_data(acc_rd_data),
    .o_result_valid(result_valid), .i_result_ready(result_ready),
    .o_result_id(result_id), .o_result_data(result_data),
`ifdef MATRIX_SEQ_PERF_EN
    .o_perf_dispatched(perf_dispatched), .o_perf_killed(perf_killed),
`endif
    .o_err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk(input logic [IDW-1:0] id, input logic [31:0] instr,
                             input logic [DW-1:0] a, input logic [DW-1:0] b, input logic we);
    op_t o;
    o.id = id; o.instr = instr; o.rs1 = a; o.rs2 = b; o.we = we;
    return o;
  endfunction

  task automatic expect_commit(input op_t o);
    res_t r;
    exp_disp.push_back(o);
    if (o.we) begin
      r.id = o.id;
      r.data = o.rs1 * o.rs2;
      exp_res.push_back(r);
    end
  endtask

  task automatic drive(input logic iv, input op_t o, input logic cv,
                       input logic [IDW-1:0] cid, input logic kill);
    @(negedge clk);
    in_valid = iv; in_instr = o.instr; in_id = o.id; in_rs1 = o.rs1; in_rs2 = o.rs2; in_we = o.we;
    commit_valid = cv; commit_id = cid; commit_kill = kill;
    @(negedge clk);
    in_valid = 1'b0;
    commit_valid = 1'b0;
  endtask

  task automatic issue(input op_t o);
    drive(1'b1, o, 1'b0, '0, 1'b0);
  endtask

  task automatic commit(input op_t o, input logic kill);
    if (!kill) expect_commit(o);
    drive(1'b0, o, 1'b1, o.id, kill);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 200; k++) begin
      if (exp_disp.size() == 0 && exp_res.size() == 0 && !acc_busy && !acc_valid && !result_valid)
        break;
      @(negedge clk);
    end
    check(tag, 64'(exp_disp.size() + exp_res.size()), 64'd0);
  endtask

  // Accelerator model: accepts one dispatch, pulses done two cycles later with rs1*rs2
  initial begin : acc_model
    op_t e;
    acc_ready = 1'b0; acc_done = 1'b0; acc_rd_data = '0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_ack) begin
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        spur_ack++;
      end else if (acc_valid) begin
        acc_busy = 1'b1;
        check("disp_expected", 64'(exp_disp.size() > 0), 64'd1);
        e = mk('0, '0, '0, '0, 1'b0);
        if (exp_disp.size() > 0) e = exp_disp.pop_front();
        check("disp_id", 64'(acc_id), 64'(e.id));
        check("disp_instr", 64'(acc_instr), 64'(e.instr));
        check("disp_rs1", acc_rs1, e.rs1);
        check("disp_rs2", acc_rs2, e.rs2);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        check("acc_valid_drop", 64'(acc_valid), 64'd0);
        acc_in_exec = 1'b1;
        if (acc_hang) begin
          while (acc_hang) @(negedge clk);
        end else begin
          repeat (2) @(negedge clk);
          acc_done = 1'b1;
          acc_rd_data = e.rs1 * e.rs2;
          @(negedge clk);
          acc_done = 1'b0;
          check("res_latency", 64'(result_valid), 64'(e.we));
        end
        acc_in_exec = 1'b0;
        acc_busy = 1'b0;
      end
    end
  end

  initial begin : res_consumer
    res_t r;
    forever begin
      @(negedge clk);
      if (result_valid && result_ready) begin
        check("res_expected", 64'(exp_res.size() > 0), 64'd1);
        if (exp_res.size() > 0) begin
          r = exp_res.pop_front();
          check("res_id", 64'(result_id), 64'(r.id));
          check("res_data", result_data, r.data);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    op_t o1, o2, o3, o4;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_id = '0; in_rs1 = '0; in_rs2 = '0; in_we = 1'b0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; result_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_acc_valid", 64'(acc_valid), 64'd0);
    check("rst_result_valid", 64'(result_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_result_data", result_data, 64'd0);
    check("rst_acc_rs1", acc_rs1, 64'd0);

    // Issue + commit in the same cycle, latency to acc_valid
    o1 = mk(4'd3, 32'h0000002B, 64'd5, 64'd7, 1'b1);
    expect_commit(o1);
    drive(1'b1, o1, 1'b1, 4'd3, 1'b0);
    check("lat_t1_acc_valid", 64'(acc_valid), 64'd0);
    @(negedge clk);
    check("lat_t2_acc_valid", 64'(acc_valid), 64'd1);
    check("lat_t2_rs1", acc_rs1, 64'd5);
    check("lat_t2_rs2", acc_rs2, 64'd7);
    wait_drain("t1_drain");
    check("t1_in_ready", 64'(in_ready), 64'd1);

    // Kill of a middle entry
    o1 = mk(4'd1, 32'h0000102B, 64'd11, 64'd3, 1'b1);
    o2 = mk(4'd2, 32'h0000202B, 64'd13, 64'd4, 1'b1);
    o3 = mk(4'd3, 32'h0000302B, 64'd17, 64'd5, 1'b1);
    issue(o1); issue(o2); issue(o3);
    commit(o2, 1'b1);
    commit(o1, 1'b0);
    commit(o3, 1'b0);
    wait_drain("t2_drain");

    // Fill all entries without commits
    o1 = mk(4'd4, 32'h11, 64'd2, 64'd3, 1'b1);
    o2 = mk(4'd5, 32'h22, 64'd4, 64'd5, 1'b1);
    o3 = mk(4'd6, 32'h33, 64'd6, 64'd7, 1'b0);
    o4 = mk(4'd7, 32'h44, 64'd8, 64'd9, 1'b1);
    issue(o1); issue(o2); issue(o3); issue(o4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    check("full_no_dispatch", 64'(acc_valid), 64'd0);
    commit(o1, 1'b0);
    for (int k = 0; k < 20 && !acc_valid; k++) @(negedge clk);
    check("full_head_dispatched", 64'(acc_valid), 64'd1);
    check("full_ready_at_disp", 64'(in_ready), 64'd0);
    for (int k = 0; k < 20 && !result_valid; k++) @(negedge clk);
    check("full_head_result", 64'(result_valid), 64'd1);
    check("full_ready_at_result", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("full_ready_after_pop", 64'(in_ready), 64'd1);
    commit(o2, 1'b0); commit(o3, 1'b0); commit(o4, 1'b0);
    wait_drain("t3_drain");

    // Result backpressure
    @(posedge clk); #1 result_ready = 1'b0;
    o1 = mk(4'd10, 32'h55, 64'd3, 64'd9, 1'b1);
    o2 = mk(4'd11, 32'h66, 64'd6, 64'd6, 1'b1);
    expect_commit(o1);
    drive(1'b1, o1, 1'b1, o1.id, 1'b0);
    expect_commit(o2);
    drive(1'b1, o2, 1'b1, o2.id, 1'b0);
    for (int k = 0; k < 20 && !result_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 64'(result_valid), 64'd1);
      check("hold_id", 64'(result_id), 64'd10);
      check("hold_data", result_data, 64'd27);
      check("hold_no_dispatch", 64'(acc_valid), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 result_ready = 1'b1;
    wait_drain("hold_drain");

    // Unmatched commit
    o1 = mk(4'd9, 32'h0, 64'd0, 64'd0, 1'b0);
    drive(1'b0, o1, 1'b1, 4'd9, 1'b0);
    check("err_set", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);
    spur_req++;
    repeat (4) @(negedge clk);
    check("err_after_spur", 64'(err), 64'd1);
    check("spur_no_dispatch", 64'(acc_valid), 64'd0);

    // Reset while the head is executing
    acc_hang = 1'b1;
    o1 = mk(4'd12, 32'h77, 64'd7, 64'd7, 1'b1);
    expect_commit(o1);
    drive(1'b1, o1, 1'b1, o1.id, 1'b0);
    for (int k = 0; k < 20 && !acc_in_exec; k++) @(negedge clk);
    check("rstx_in_exec", 64'(acc_in_exec), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstx_acc_valid", 64'(acc_valid), 64'd0);
    check("rstx_result_valid", 64'(result_valid), 64'd0);
    check("rstx_err", 64'(err), 64'd0);
    check("rstx_in_ready", 64'(in_ready), 64'd1);
    check("rstx_acc_id", 64'(acc_id), 64'd0);
    rst = 1'b0;
    acc_hang = 1'b0;
    exp_res.delete();
    repeat (5) @(negedge clk);
    check("rstx_no_result", 64'(result_valid), 64'd0);
    check("rstx_no_dispatch", 64'(acc_valid), 64'd0);

    // Spurious done in IDLE after a clean reset
    spur_req++;
    repeat (4) @(negedge clk);
    check("spur_err", 64'(err), 64'd1);
    check("spur_no_result", 64'(result_valid), 64'd0);
    check("spur_in_ready", 64'(in_ready), 64'd1);

    // Mixed commits and kills
    o1 = mk(4'd1, 32'h101, 64'd2, 64'd2, 1'b1);
    o2 = mk(4'd2, 32'h102, 64'd3, 64'd3, 1'b1);
    o3 = mk(4'd3, 32'h103, 64'd4, 64'd4, 1'b1);
    o4 = mk(4'd4, 32'h104, 64'd5, 64'd5, 1'b1);
    issue(o1); issue(o2); issue(o3); issue(o4);
    commit(o2, 1'b1);
    commit(o4, 1'b1);
    commit(o1, 1'b0);
    commit(o3, 1'b0);
    wait_drain("mix_drain");
    o1 = mk(4'd5, 32'h105, 64'd6, 64'd6, 1'b1);
    expect_commit(o1);
    drive(1'b1, o1, 1'b1, o1.id, 1'b0);
    wait_drain("mix_drain2");
`ifdef MATRIX_SEQ_PERF_EN
    check("perf_dispatched", 64'(perf_dispatched), 64'd3);
    check("perf_killed", 64'(perf_killed), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
